battle_phase_sequencer: RTL and testbench

- Parametrised top-level turn sequencer for the battle screen.
- Steps through N_PHASES gameplay phases (default: 0 = menu, 1 = player attack, 2 = enemy attack) on rising edges of each phase's finish flag, then issues a one-cycle round reset.
- On a game-over event it latches permanently into an over state and runs a timed, multi-stage end animation with a frame-locked fade level.
- Pixel mixing stays outside this block; the mixer consumes phase_out, anim_stage_out and fade_level_out.

---
 rtl/battle_phase_sequencer.sv | 144 ++++++++++++++
 tb/tb_battle_phase_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/battle_phase_sequencer.sv
// Battle-screen turn sequencer: walks gameplay phases on finish edges, pulses a round reset,
// and on game over latches into a timed, frame-locked end animation.
module battle_phase_sequencer #(
    parameter int unsigned N_PHASES     = 3,
    parameter int unsigned PHASE_W      = 3,
    parameter int unsigned ANIM_STAGES  = 4,
    parameter int unsigned STAGE_CYCLES = 130000000,
    parameter int unsigned FADE_DIV     = 8,
    parameter int unsigned FADE_MAX     = 15,
    parameter int unsigned ROUND_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PHASES-1:0] finish_in,
    input  logic                game_over_in,
    input  logic                frame_start_in,
    output logic [PHASE_W-1:0]  phase_out,
    output logic                round_rst_out,
    output logic [ROUND_W-1:0]  round_count_out,
    output logic                game_over_out,
    output logic [2:0]          anim_stage_out,
    output logic [3:0]          fade_level_out
);

    localparam int unsigned SC_W = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
    localparam int unsigned FD_W = ($clog2(FADE_DIV) > 3) ? $clog2(FADE_DIV) : 3;

    localparam logic [SC_W-1:0]    STAGE_LAST = SC_W'(STAGE_CYCLES - 1);
    localparam logic [FD_W-1:0]    DIV_LAST   = FD_W'(FADE_DIV - 1);
    localparam logic [2:0]         ANIM_LAST  = 3'(ANIM_STAGES - 1);
    localparam logic [3:0]         FADE_TOP   = 4'(FADE_MAX);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(N_PHASES - 1);

    localparam logic [1:0] StRun      = 2'd0;
    localparam logic [1:0] StRoundRst = 2'd1;
    localparam logic [1:0] StOver     = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic                round_rst_q, round_rst_d;
    logic [ROUND_W-1:0]  round_cnt_q, round_cnt_d;
    logic [2:0]          anim_q, anim_d;
    logic [SC_W-1:0]     stage_cnt_q, stage_cnt_d;
    logic [FD_W-1:0]     frame_div_q, frame_div_d;
    logic [3:0]          fade_q, fade_d;
    logic [N_PHASES-1:0] finish_prev_q;
    logic                game_over_prev_q;

    logic [N_PHASES-1:0] finish_rise;
    logic                phase_rise;
    logic                game_over_rise;

    assign finish_rise    = finish_in & ~finish_prev_q;
    // Only the active phase's flag can advance the sequence; other edges are dropped.
    assign phase_rise     = |(finish_rise & (N_PHASES'(1) << phase_q));
    assign game_over_rise = game_over_in & ~game_over_prev_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        round_rst_d = 1'b0;
        round_cnt_d = round_cnt_q;
        anim_d      = anim_q;
        stage_cnt_d = stage_cnt_q;
        frame_div_d = frame_div_q;
        fade_d      = fade_q;
        case (state_q)
            StRun, StRoundRst: begin
                if (game_over_rise) begin
                    state_d     = StOver;
                    anim_d      = 3'd0;
                    stage_cnt_d = '0;
                    frame_div_d = '0;
                    fade_d      = 4'd0;
                end else if (state_q == StRoundRst) begin
                    state_d = StRun;
                end else if (phase_rise) begin
                    if (phase_q == PHASE_LAST) begin
                        state_d     = StRoundRst;
                        round_rst_d = 1'b1;
                        phase_d     = '0;
                        if (!(&round_cnt_q)) round_cnt_d = round_cnt_q + 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            StOver: begin
                if (anim_q < ANIM_LAST) begin
                    if (stage_cnt_q == STAGE_LAST) begin
                        anim_d      = anim_q + 1'b1;
                        stage_cnt_d = '0;
                    end else begin
                        stage_cnt_d = stage_cnt_q + 1'b1;
                    end
                end else if (frame_start_in) begin
                    if (frame_div_q == DIV_LAST) begin
                        frame_div_d = '0;
                        if (fade_q < FADE_TOP) fade_d = fade_q + 1'b1;
                    end else begin
                        frame_div_d = frame_div_q + 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            phase_q     <= '0;
            round_rst_q <= 1'b0;
            round_cnt_q <= '0;
            anim_q      <= 3'd0;
            stage_cnt_q <= '0;
            frame_div_q <= '0;
            fade_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            round_rst_q <= round_rst_d;
            round_cnt_q <= round_cnt_d;
            anim_q      <= anim_d;
            stage_cnt_q <= stage_cnt_d;
            frame_div_q <= frame_div_d;
            fade_q      <= fade_d;
        end
    end

    // Edge history loads during reset too, so a level already high at release is not an edge.
    always_ff @(posedge clk) begin
        finish_prev_q    <= finish_in;
        game_over_prev_q <= game_over_in;
    end

    assign phase_out       = phase_q;
    assign round_rst_out   = round_rst_q;
    assign round_count_out = round_cnt_q;
    assign game_over_out   = (state_q == StOver);
    assign anim_stage_out  = anim_q;
    assign fade_level_out  = fade_q;

endmodule

// File: tb/tb_battle_phase_sequencer.sv
// Directed bench for battle_phase_sequencer with short animation timing.
module tb_battle_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] finish_in;
    logic       game_over_in;
    logic       frame_start_in;
    logic [2:0] phase_out;
    logic       round_rst_out;
    logic [7:0] round_count_out;
    logic       game_over_out;
    logic [2:0] anim_stage_out;
    logic [3:0] fade_level_out;

    int checks = 0;
    int errors = 0;

    battle_phase_sequencer #(
        .N_PHASES     (3),
        .PHASE_W      (3),
        .ANIM_STAGES  (4),
        .STAGE_CYCLES (5),
        .FADE_DIV     (2),
        .FADE_MAX     (3),
        .ROUND_W      (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .finish_in       (finish_in),
        .game_over_in    (game_over_in),
        .frame_start_in  (frame_start_in),
        .phase_out       (phase_out),
        .round_rst_out   (round_rst_out),
        .round_count_out (round_count_out),
        .game_over_out   (game_over_out),
        .anim_stage_out  (anim_stage_out),
        .fade_level_out  (fade_level_out)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".phase"}, int'(phase_out), 0);
        check({tag, ".round_rst"}, int'(round_rst_out), 0);
        check({tag, ".round_count"}, int'(round_count_out), 0);
        check({tag, ".game_over"}, int'(game_over_out), 0);
        check({tag, ".anim"}, int'(anim_stage_out), 0);
        check({tag, ".fade"}, int'(fade_level_out), 0);
    endtask

    initial begin
        int exp_anim;
        int exp_fade;
        rst = 1'b1;
        finish_in = 3'b000;
        game_over_in = 1'b0;
        frame_start_in = 1'b0;
        step(2);
        check_all_zero("reset");
        rst = 1'b0;
        step(1);

        // Full round
        finish_in = 3'b001;
        step(1);
        check("round.p1", int'(phase_out), 1);
        step(9);
        finish_in = 3'b011;
        step(1);
        check("round.p2", int'(phase_out), 2);
        step(9);
        finish_in = 3'b111;
        step(1);
        check("round.rst_pulse", int'(round_rst_out), 1);
        check("round.p0", int'(phase_out), 0);
        check("round.count", int'(round_count_out), 1);
        step(1);
        check("round.rst_drop", int'(round_rst_out), 0);
        check("round.p0_hold", int'(phase_out), 0);

        // Edge on a non-current phase is ignored
        finish_in = 3'b011;
        step(1);
        finish_in = 3'b111;
        step(1);
        check("other.phase", int'(phase_out), 0);
        check("other.round_rst", int'(round_rst_out), 0);
        step(1);
        check("other.count", int'(round_count_out), 1);

        // finish_in[0] held high through reset release
        rst = 1'b1;
        finish_in = 3'b001;
        step(1);
        rst = 1'b0;
        step(3);
        check("held.phase", int'(phase_out), 0);
        check("held.count", int'(round_count_out), 0);

        // Game over beats a simultaneous finish edge
        finish_in = 3'b000;
        step(1);
        finish_in = 3'b001;
        game_over_in = 1'b1;
        step(1);
        check("over.flag", int'(game_over_out), 1);
        check("over.phase", int'(phase_out), 0);
        check("over.anim", int'(anim_stage_out), 0);
        check("over.round_rst", int'(round_rst_out), 0);

        // Stage timing; early frame pulses and finish/game-over churn ignored
        for (int i = 1; i <= 20; i++) begin
            frame_start_in = (i % 4 == 1) && (i < 16);
            finish_in = (i % 2 == 1) ? 3'b111 : 3'b000;
            game_over_in = (i % 3 != 0);
            step(1);
            exp_anim = (i / 5 > 3) ? 3 : i / 5;
            check($sformatf("anim.i%0d", i), int'(anim_stage_out), exp_anim);
            check($sformatf("anim.fade%0d", i), int'(fade_level_out), 0);
        end
        check("anim.phase", int'(phase_out), 0);
        check("anim.over", int'(game_over_out), 1);
        frame_start_in = 1'b0;

        // Fade every 2 pulses, saturating at 3
        for (int p = 1; p <= 20; p++) begin
            frame_start_in = 1'b1;
            step(1);
            frame_start_in = 1'b0;
            step(3);
            exp_fade = (p / 2 > 3) ? 3 : p / 2;
            check($sformatf("fade.p%0d", p), int'(fade_level_out), exp_fade);
        end
        check("fade.anim", int'(anim_stage_out), 3);

        // Reset mid-fade
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        game_over_in = 1'b0;
        finish_in = 3'b000;
        step(1);
        game_over_in = 1'b1;
        step(1);
        check("refade.over", int'(game_over_out), 1);
        step(15);
        check("refade.anim", int'(anim_stage_out), 3);
        for (int p = 0; p < 2; p++) begin
            frame_start_in = 1'b1;
            step(1);
            frame_start_in = 1'b0;
            step(3);
        end
        check("refade.fade", int'(fade_level_out), 1);
        finish_in = 3'b111;
        rst = 1'b1;
        step(1);
        check_all_zero("rst_fade");
        rst = 1'b0;
        step(3);
        check("rst_fade.phase_after", int'(phase_out), 0);
        check("rst_fade.over_after", int'(game_over_out), 0);

        // Reset during the round-reset pulse
        finish_in = 3'b000;
        step(1);
        finish_in = 3'b001;
        step(1);
        finish_in = 3'b011;
        step(1);
        finish_in = 3'b111;
        step(1);
        check("rst_rr.pulse", int'(round_rst_out), 1);
        rst = 1'b1;
        step(1);
        check_all_zero("rst_rr");
        rst = 1'b0;
        step(3);
        check("rst_rr.phase_after", int'(phase_out), 0);
        check("rst_rr.pulse_after", int'(round_rst_out), 0);
        check("rst_rr.count_after", int'(round_count_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
